wb_port_arbiter: RTL and testbench

Oldest-first arbiter that shares the two writeback slots (inst0/inst1) among NUM_REQ functional-unit completion ports (ALU0, ALU1, MUL/DIV, LSU). Each cycle it picks up to two completed results by scoreboard age, registers them, and presents them to the writeback stage's inst0/inst1 inputs. It owns the valid/ready handshake toward the units, holds its output on writeback stall, and discards younger results on a redirect flush.

---
 rtl/wb_port_arbiter_pkg.sv | 24 ++
 rtl/wb_port_arbiter_if.sv | 59 +++++
 rtl/wb_port_arbiter_age_picker.sv | 36 +++
 rtl/wb_port_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-arbiter types: scoreboard id width, completion payload
// struct and the modular age helper also used by the scoreboard.
package wb_port_arbiter_pkg;

    localparam int SCOREBOARD_SIZE_WIDTH = 4;
    localparam int SID_W                 = SCOREBOARD_SIZE_WIDTH + 1;

    typedef logic [SID_W-1:0] sid_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] value;
        logic        redirect;
        logic [63:0] redirect_pc;
        sid_t        sid;
    } wb_req_t;

    // Distance from the scoreboard head; the wrap bit makes plain
    // subtraction order ids correctly across the wrap point.
    function automatic sid_t age(input sid_t s, input sid_t head);
        return s - head;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Completion-port and writeback-slot bundle between the functional units,
// the writeback stage and wb_port_arbiter.
interface wb_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SID_W   = wb_port_arbiter_pkg::SID_W
);

    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0][4:0]        req_rd_i;
    logic [NUM_REQ-1:0][63:0]       req_value_i;
    logic [NUM_REQ-1:0]             req_redirect_i;
    logic [NUM_REQ-1:0][63:0]       req_redirect_pc_i;
    logic [NUM_REQ-1:0][SID_W-1:0]  req_sid_i;
    logic [NUM_REQ-1:0]             req_ready_o;

    logic [SID_W-1:0]               head_sid_i;
    logic                           stall_i;
    logic                           flush_i;
    logic [SID_W-1:0]               flush_sid_i;

    logic                           slot0_valid_o;
    logic [4:0]                     slot0_rd_o;
    logic [63:0]                    slot0_value_o;
    logic                           slot0_redirect_o;
    logic [63:0]                    slot0_redirect_pc_o;
    logic [SID_W-1:0]               slot0_sid_o;

    logic                           slot1_valid_o;
    logic [4:0]                     slot1_rd_o;
    logic [63:0]                    slot1_value_o;
    logic                           slot1_redirect_o;
    logic [63:0]                    slot1_redirect_pc_o;
    logic [SID_W-1:0]               slot1_sid_o;

    // Environment side: functional units plus writeback/scoreboard control.
    modport master (
        output req_valid_i, req_rd_i, req_value_i, req_redirect_i,
               req_redirect_pc_i, req_sid_i, head_sid_i, stall_i,
               flush_i, flush_sid_i,
        input  req_ready_o,
               slot0_valid_o, slot0_rd_o, slot0_value_o, slot0_redirect_o,
               slot0_redirect_pc_o, slot0_sid_o,
               slot1_valid_o, slot1_rd_o, slot1_value_o, slot1_redirect_o,
               slot1_redirect_pc_o, slot1_sid_o
    );

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_rd_i, req_value_i, req_redirect_i,
               req_redirect_pc_i, req_sid_i, head_sid_i, stall_i,
               flush_i, flush_sid_i,
        output req_ready_o,
               slot0_valid_o, slot0_rd_o, slot0_value_o, slot0_redirect_o,
               slot0_redirect_pc_o, slot0_sid_o,
               slot1_valid_o, slot1_rd_o, slot1_value_o, slot1_redirect_o,
               slot1_redirect_pc_o, slot1_sid_o
    );

endinterface

// File: rtl/wb_port_arbiter_age_picker.sv
// Oldest-valid selector: one-hot grant of the valid requester with the
// smallest age relative to head; ties resolve to the lower index.
module wb_age_picker #(
    parameter int NUM_REQ = 4,
    parameter int SID_W   = 5
) (
    input  logic [NUM_REQ-1:0]             valid,
    input  logic [NUM_REQ-1:0][SID_W-1:0]  sid,
    input  logic [SID_W-1:0]               head,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           found
);

    logic [SID_W-1:0] best_age;
    logic [SID_W-1:0] cand_age;

    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        best_age = '0;
        cand_age = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_age = sid[k] - head;
            // Strict compare keeps the earlier (lower-index) winner on ties.
            if (valid[k] && (!found || cand_age < best_age)) begin
                grant    = '0;
                grant[k] = 1'b1;
                found    = 1'b1;
                best_age = cand_age;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Oldest-first arbiter sharing the two writeback slots among NUM_REQ
// completion ports, with stall hold and redirect-flush pruning.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_port_arbiter_if.slave bus
);

    wb_req_t              req [NUM_REQ];
    logic [NUM_REQ-1:0]   grant_a;
    logic [NUM_REQ-1:0]   grant_b;
    logic [NUM_REQ-1:0]   grant_b_eff;
    logic                 found_a;
    logic                 found_b;
    wb_req_t              a_req;
    wb_req_t              b_req;

    wb_req_t              slot0_q;
    wb_req_t              slot1_q;
    logic                 slot0_valid_q;
    logic                 slot1_valid_q;

    logic                 advance;
    logic                 accept;
    logic                 take_b;
    sid_t                 flush_age;
    logic                 kill0;
    logic                 kill1;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req[k].rd          = bus.req_rd_i[k];
            req[k].value       = bus.req_value_i[k];
            req[k].redirect    = bus.req_redirect_i[k];
            req[k].redirect_pc = bus.req_redirect_pc_i[k];
            req[k].sid         = bus.req_sid_i[k];
        end
    end

    wb_age_picker #(.NUM_REQ(NUM_REQ), .SID_W(SID_W)) u_pick_a (
        .valid (bus.req_valid_i),
        .sid   (bus.req_sid_i),
        .head  (bus.head_sid_i),
        .grant (grant_a),
        .found (found_a)
    );

    wb_age_picker #(.NUM_REQ(NUM_REQ), .SID_W(SID_W)) u_pick_b (
        .valid (bus.req_valid_i & ~grant_a),
        .sid   (bus.req_sid_i),
        .head  (bus.head_sid_i),
        .grant (grant_b),
        .found (found_b)
    );

    // One-hot payload muxes; no grant yields an all-zero payload.
    always_comb begin
        a_req = '0;
        b_req = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_a[k]) a_req = req[k];
            if (grant_b[k]) b_req = req[k];
        end
    end

    // A redirect on either pick must travel alone, in slot0.
    assign take_b      = found_b && !a_req.redirect && !b_req.redirect;
    assign grant_b_eff = take_b ? grant_b : '0;

    assign advance = !bus.stall_i || !slot0_valid_q;
    assign accept  = advance && !bus.flush_i;

    assign bus.req_ready_o = (accept && rst_n) ? (grant_a | grant_b_eff) : '0;

    assign flush_age = age(bus.flush_sid_i, bus.head_sid_i);
    assign kill0     = slot0_valid_q && (age(slot0_q.sid, bus.head_sid_i) > flush_age);
    assign kill1     = slot1_valid_q && (age(slot1_q.sid, bus.head_sid_i) > flush_age);

    // NOTE: payload registers are reset too, so the slot outputs read as
    // zero after reset rather than leaking stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q       <= '0;
            slot1_q       <= '0;
            slot0_valid_q <= 1'b0;
            slot1_valid_q <= 1'b0;
        end else if (bus.flush_i && !advance) begin
            // Stalled flush: prune younger slots in place, compacting into slot0.
            if (kill0 && slot1_valid_q && !kill1) begin
                slot0_q          <= slot1_q;
                slot0_valid_q    <= 1'b1;
                slot1_valid_q    <= 1'b0;
                slot1_q.redirect <= 1'b0;
            end else begin
                if (kill0) begin
                    slot0_valid_q    <= 1'b0;
                    slot0_q.redirect <= 1'b0;
                end
                if (kill1) begin
                    slot1_valid_q    <= 1'b0;
                    slot1_q.redirect <= 1'b0;
                end
            end
        end else if (advance) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            slot0_valid_q <= accept && found_a;
            slot0_q       <= (accept && found_a) ? a_req : '0;
            slot1_valid_q <= accept && take_b;
            slot1_q       <= (accept && take_b) ? b_req : '0;
        end
    end

    assign bus.slot0_valid_o       = slot0_valid_q;
    assign bus.slot0_rd_o          = slot0_q.rd;
    assign bus.slot0_value_o       = slot0_q.value;
    assign bus.slot0_redirect_o    = slot0_q.redirect;
    assign bus.slot0_redirect_pc_o = slot0_q.redirect_pc;
    assign bus.slot0_sid_o         = slot0_q.sid;

    assign bus.slot1_valid_o       = slot1_valid_q;
    assign bus.slot1_rd_o          = slot1_q.rd;
    assign bus.slot1_value_o       = slot1_q.value;
    assign bus.slot1_redirect_o    = slot1_q.redirect;
    assign bus.slot1_redirect_pc_o = slot1_q.redirect_pc;
    assign bus.slot1_sid_o         = slot1_q.sid;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter: ordering, redirect,
// sid wrap, stall, flush and mid-operation reset.
module tb_wb_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    wb_port_arbiter_if #(.NUM_REQ(4), .SID_W(5)) bus ();

    wb_port_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] sid, input logic redir);
        bus.req_valid_i[k]       = 1'b1;
        bus.req_rd_i[k]          = 5'(k + 1);
        bus.req_value_i[k]       = 64'hA000 + 64'(sid);
        bus.req_redirect_i[k]    = redir;
        bus.req_redirect_pc_i[k] = 64'h1000 + 64'(sid);
        bus.req_sid_i[k]         = sid;
    endtask

    task automatic drop_req(input int k);
        bus.req_valid_i[k]    = 1'b0;
        bus.req_redirect_i[k] = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 4; k++) drop_req(k);
    endtask

    task automatic check_slots(input string tag, input logic v0, input logic [4:0] s0,
                               input logic v1, input logic [4:0] s1);
        check({tag, ".v0"}, 64'(bus.slot0_valid_o), 64'(v0));
        if (v0) check({tag, ".s0"}, 64'(bus.slot0_sid_o), 64'(s0));
        check({tag, ".v1"}, 64'(bus.slot1_valid_o), 64'(v1));
        if (v1) check({tag, ".s1"}, 64'(bus.slot1_sid_o), 64'(s1));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.req_valid_i       = '0;
        bus.req_rd_i          = '0;
        bus.req_value_i       = '0;
        bus.req_redirect_i    = '0;
        bus.req_redirect_pc_i = '0;
        bus.req_sid_i         = '0;
        bus.head_sid_i        = '0;
        bus.stall_i           = 1'b0;
        bus.flush_i           = 1'b0;
        bus.flush_sid_i       = '0;

        // Reset state
        step();
        check("rst.v0", 64'(bus.slot0_valid_o), 64'd0);
        check("rst.v1", 64'(bus.slot1_valid_o), 64'd0);
        check("rst.ready", 64'(bus.req_ready_o), 64'd0);
        check("rst.value0", bus.slot0_value_o, 64'd0);
        check("rst.redir0", 64'(bus.slot0_redirect_o), 64'd0);
        rst_n = 1'b1;
        step();

        // Independent requests: sid 3 then sid 5, sid 7 waits
        set_req(0, 5'd5, 1'b0);
        set_req(1, 5'd3, 1'b0);
        set_req(2, 5'd7, 1'b0);
        #1;
        check("ind.ready", 64'(bus.req_ready_o), 64'b0011);
        step();
        check_slots("ind.c1", 1'b1, 5'd3, 1'b1, 5'd5);
        check("ind.rd0", 64'(bus.slot0_rd_o), 64'd2);
        check("ind.val0", bus.slot0_value_o, 64'hA003);
        check("ind.rd1", 64'(bus.slot1_rd_o), 64'd1);
        drop_req(0);
        drop_req(1);
        #1;
        check("ind.ready2", 64'(bus.req_ready_o), 64'b0100);
        step();
        check_slots("ind.c2", 1'b1, 5'd7, 1'b0, 5'd0);
        clear_reqs();

        // Redirect travels alone in slot0
        set_req(0, 5'd2, 1'b1);
        set_req(1, 5'd1, 1'b0);
        #1;
        check("rdr.ready", 64'(bus.req_ready_o), 64'b0010);
        step();
        check_slots("rdr.c1", 1'b1, 5'd1, 1'b0, 5'd0);
        check("rdr.c1.r0", 64'(bus.slot0_redirect_o), 64'd0);
        drop_req(1);
        #1;
        check("rdr.ready2", 64'(bus.req_ready_o), 64'b0001);
        step();
        check_slots("rdr.c2", 1'b1, 5'd2, 1'b0, 5'd0);
        check("rdr.c2.r0", 64'(bus.slot0_redirect_o), 64'd1);
        check("rdr.c2.pc", bus.slot0_redirect_pc_o, 64'h1002);
        clear_reqs();
        step();
        check("rdr.empty", 64'(bus.slot0_valid_o), 64'd0);

        // Sid wrap: head 30, sid 31 older than sid 1
        bus.head_sid_i = 5'd30;
        set_req(0, 5'd1, 1'b0);
        set_req(1, 5'd31, 1'b0);
        #1;
        check("wrap.ready", 64'(bus.req_ready_o), 64'b0011);
        step();
        check_slots("wrap", 1'b1, 5'd31, 1'b1, 5'd1);
        clear_reqs();

        // Stall holds slots for 3 cycles with no ready
        bus.stall_i = 1'b1;
        set_req(2, 5'd0, 1'b0);
        set_req(3, 5'd2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall.ready%0d", c), 64'(bus.req_ready_o), 64'd0);
            step();
            check_slots($sformatf("stall.hold%0d", c), 1'b1, 5'd31, 1'b1, 5'd1);
        end
        bus.stall_i = 1'b0;
        #1;
        check("stall.rel.ready", 64'(bus.req_ready_o), 64'b1100);
        step();
        check_slots("stall.rel", 1'b1, 5'd0, 1'b1, 5'd2);
        clear_reqs();
        bus.head_sid_i = 5'd0;

        // Flush at sid 4 keeps slot0 (sid 4), kills slot1 (sid 6)
        set_req(0, 5'd4, 1'b0);
        set_req(1, 5'd6, 1'b0);
        step();
        check_slots("fl.load", 1'b1, 5'd4, 1'b1, 5'd6);
        clear_reqs();
        bus.stall_i     = 1'b1;
        bus.flush_i     = 1'b1;
        bus.flush_sid_i = 5'd4;
        set_req(2, 5'd1, 1'b0);
        #1;
        check("fl4.ready", 64'(bus.req_ready_o), 64'd0);
        step();
        bus.flush_i = 1'b0;
        check_slots("fl4", 1'b1, 5'd4, 1'b0, 5'd0);
        clear_reqs();
        bus.stall_i = 1'b0;
        step();
        check("fl4.drain", 64'(bus.slot0_valid_o), 64'd0);

        // Flush at sid 3 kills both
        set_req(0, 5'd4, 1'b0);
        set_req(1, 5'd6, 1'b0);
        step();
        clear_reqs();
        bus.stall_i     = 1'b1;
        bus.flush_i     = 1'b1;
        bus.flush_sid_i = 5'd3;
        step();
        bus.flush_i = 1'b0;
        check_slots("fl3", 1'b0, 5'd0, 1'b0, 5'd0);
        check("fl3.redir0", 64'(bus.slot0_redirect_o), 64'd0);
        bus.stall_i = 1'b0;

        // Reset mid-burst clears asynchronously; grant lands cycle+1
        set_req(0, 5'd1, 1'b0);
        set_req(1, 5'd2, 1'b0);
        step();
        check_slots("mid.load", 1'b1, 5'd1, 1'b1, 5'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.v0", 64'(bus.slot0_valid_o), 64'd0);
        check("mid.v1", 64'(bus.slot1_valid_o), 64'd0);
        check("mid.ready", 64'(bus.req_ready_o), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mid.rel.ready", 64'(bus.req_ready_o), 64'b0011);
        step();
        check_slots("mid.rel", 1'b1, 5'd1, 1'b1, 5'd2);
        clear_reqs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
